// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM port arbiter.
package dram_arb_pkg;

  localparam int DEF_BLOCK_W = 256;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RD_WAIT,
    WR_WAIT,
    RESP
  } state_t;

  // Number of byte-offset bits inside one DRAM block.
  function automatic int OFFS_BITS(input int block_w);
    return $clog2(block_w / 8);
  endfunction

endpackage

// File: rtl/dram_port_arbiter_rr_arbiter2.sv
// Two-input round-robin grant logic with its priority pointer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       last_grant,
  output logic       grant
);

  logic ptr;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    grant = ptr;
    if (req == 2'b01)
      grant = 1'b0;
    else if (req == 2'b10)
      grant = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= 1'b0;
    else if (advance)
      ptr <= ~last_grant;
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one DRAM block port between the L2 data and instruction requesters,
// one transaction at a time, with read timeout detection.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  input  logic [1:0]         req_we,
  input  logic [ADDR_W-1:0]  req_addr0,
  input  logic [ADDR_W-1:0]  req_addr1,
  input  logic [BLOCK_W-1:0] req_wdata0,
  input  logic [BLOCK_W-1:0] req_wdata1,
  output logic [1:0]         req_ready,
  output logic [1:0]         rsp_valid,
  output logic               rsp_err,
  output logic [BLOCK_W-1:0] rsp_data,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_en,
  output logic               mem_we,
  output logic [BLOCK_W-1:0] mem_din,
  input  logic [BLOCK_W-1:0] mem_dout,
  input  logic               mem_dready,
  input  logic               mem_accR,
  input  logic               mem_accW,
  output logic               err_sticky
);

  localparam int OFFS = OFFS_BITS(BLOCK_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFFS;

  state_t             state;
  logic               owner;
  logic               we_q;
  logic               wr_skip;
  logic [CNT_W-1:0]   cnt;
  logic               grant;
  logic               arb_go;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [BLOCK_W-1:0] sel_wdata;
  logic [1:0]         owner_onehot;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (req_valid),
    .advance    (state == ISSUE),
    .last_grant (owner),
    .grant      (grant)
  );

  assign arb_go       = (state == IDLE) && (req_valid != 2'b00) && mem_accR && mem_accW;
  assign sel_we       = req_we[grant];
  assign sel_addr     = grant ? req_addr1 : req_addr0;
  assign sel_wdata    = grant ? req_wdata1 : req_wdata0;
  assign owner_onehot = owner ? 2'b10 : 2'b01;

  // Strobes and accept pulses are registered on entry to ISSUE so they last exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      wr_skip    <= 1'b0;
      cnt        <= '0;
      req_ready  <= 2'b00;
      rsp_valid  <= 2'b00;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      mem_addr   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_din    <= '0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_go) begin
            owner     <= grant;
            we_q      <= sel_we;
            mem_addr  <= sel_addr & ALIGN_MASK;
            mem_din   <= sel_wdata;
            mem_en    <= ~sel_we;
            mem_we    <= sel_we;
            req_ready <= grant ? 2'b10 : 2'b01;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          req_ready <= 2'b00;
          cnt       <= '0;
          wr_skip   <= 1'b1;
          state     <= we_q ? WR_WAIT : RD_WAIT;
        end
        RD_WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_dready) begin
            rsp_data  <= mem_dout;
            rsp_valid <= owner_onehot;
            state     <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_data   <= '0;
            rsp_err    <= 1'b1;
            err_sticky <= 1'b1;
            rsp_valid  <= owner_onehot;
            state      <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= 2'b00;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end
        WR_WAIT: begin
          // accW only drops a cycle after the strobe, so its first sample is stale.
          if (wr_skip)
            wr_skip <= 1'b0;
          else if (mem_accW)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed self-checking bench for dram_port_arbiter with a small DRAM model.
module tb_dram_port_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_we = 2'b00;
  logic [31:0]  req_addr0 = '0;
  logic [31:0]  req_addr1 = '0;
  logic [255:0] req_wdata0 = '0;
  logic [255:0] req_wdata1 = '0;
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic         rsp_err;
  logic [255:0] rsp_data;
  logic [31:0]  mem_addr;
  logic         mem_en;
  logic         mem_we;
  logic [255:0] mem_din;
  logic [255:0] mem_dout;
  logic         mem_dready;
  logic         mem_accR;
  logic         mem_accW;
  logic         err_sticky;

  logic         model_accR;
  logic         model_accW;
  logic         busy_r = 1'b0;
  logic         no_dready = 1'b0;
  int           rd_lat = 5;
  int           wr_lat = 3;
  int           rd_cnt;
  int           wr_cnt;
  bit           wr_pend;
  logic [31:0]  rd_addr;
  logic [255:0] mem_arr [logic [31:0]];

  int total = 0;
  int bad = 0;
  int overlap = 0;
  int both_strobe = 0;
  int rsp_seen = 0;

  always #5 clk = ~clk;

  assign mem_accR = model_accR & ~busy_r;
  assign mem_accW = model_accW;

  dram_port_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_data   (rsp_data),
    .mem_addr   (mem_addr),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .mem_dready (mem_dready),
    .mem_accR   (mem_accR),
    .mem_accW   (mem_accW),
    .err_sticky (err_sticky)
  );

  function automatic logic [255:0] pattern(input logic [31:0] a);
    return {8{a}};
  endfunction

  function automatic logic [255:0] rd_block(input logic [31:0] a);
    if (mem_arr.exists(a))
      return mem_arr[a];
    return pattern(a);
  endfunction

  // DRAM model: acts 2 time units after each rising edge, clear of the bench's sampling edge.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      model_accR = 1'b1;
      model_accW = 1'b1;
      mem_dready = 1'b0;
      mem_dout   = '0;
      rd_cnt     = 0;
      wr_cnt     = 0;
      wr_pend    = 1'b0;
    end else begin
      mem_dready = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          model_accR = 1'b1;
          if (!no_dready) begin
            mem_dready = 1'b1;
            mem_dout   = rd_block(rd_addr);
          end
        end
      end
      if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0)
          model_accW = 1'b1;
      end
      if (wr_pend) begin
        wr_pend    = 1'b0;
        model_accW = 1'b0;
        wr_cnt     = wr_lat;
      end
      if ((mem_en || mem_we) && (!model_accR || !model_accW || rd_cnt > 0 || wr_pend))
        overlap++;
      if (mem_en && mem_we)
        both_strobe++;
      if (mem_en) begin
        model_accR = 1'b0;
        rd_cnt     = rd_lat;
        rd_addr    = mem_addr;
      end
      if (mem_we) begin
        mem_arr[mem_addr] = mem_din;
        wr_pend = 1'b1;
      end
      if (rsp_valid != 2'b00)
        rsp_seen++;
    end
  end

  task automatic wait_ready(input int idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == 2'b00 && n < 200);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_err, mem_en, mem_we, err_sticky} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_ctrl got=%b exp=0", {req_ready, rsp_valid, rsp_err, mem_en, mem_we, err_sticky});
    end
    total++;
    if (mem_addr !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_addr got=%h exp=0", mem_addr);
    end
    total++;
    if (rsp_data !== '0 || mem_din !== '0) begin
      bad++;
      $display("[TB] FAIL reset_data got rsp=%h din=%h exp=0", rsp_data, mem_din);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    bit ok;
    bit held;
    int n;
    req_addr0 = 32'h0001_0083;
    req_we    = 2'b00;
    req_valid = 2'b01;
    wait_ready(0, ok);
    req_valid = 2'b00;
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL single_ready got=none exp=req_ready[0]");
    end
    total++;
    if (mem_addr !== 32'h0001_0080) begin
      bad++;
      $display("[TB] FAIL single_addr got=%h exp=00010080", mem_addr);
    end
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_strobe got en=%b we=%b exp en=1 we=0", mem_en, mem_we);
    end
    @(negedge clk);
    total++;
    if (mem_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_pulse got en=%b exp=0", mem_en);
    end
    held = 1'b1;
    n = 0;
    while (mem_dready !== 1'b1 && n < 100) begin
      if (mem_addr !== 32'h0001_0080)
        held = 1'b0;
      @(negedge clk);
      n++;
    end
    total++;
    if (!held || n >= 100) begin
      bad++;
      $display("[TB] FAIL single_hold got held=%b wait=%0d exp held=1 wait<100", held, n);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_rsp got valid=%b err=%b exp valid=01 err=0", rsp_valid, rsp_err);
    end
    total++;
    if (rsp_data !== {8{32'h0001_0080}}) begin
      bad++;
      $display("[TB] FAIL single_data got=%h exp=%h", rsp_data, {8{32'h0001_0080}});
    end
    @(negedge clk);
  endtask

  task automatic test_write_readback();
    bit ok;
    bit early;
    int n;
    req_addr1  = 32'h0002_0000;
    req_wdata1 = {32{8'hA5}};
    req_we     = 2'b10;
    req_valid  = 2'b10;
    wait_ready(1, ok);
    total++;
    if (!ok || mem_we !== 1'b1 || mem_en !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wr_issue got ok=%b we=%b en=%b exp ok=1 we=1 en=0", ok, mem_we, mem_en);
    end
    req_we = 2'b00;
    early = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_en && !mem_accW)
        early = 1'b1;
    end while (!req_ready[1] && n < 100);
    req_valid = 2'b00;
    total++;
    if (n !== 6 || early || mem_en !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wr_then_rd got gap=%0d early=%b en=%b exp gap=6 early=0 en=1", n, early, mem_en);
    end
    wait_rsp(n);
    total++;
    if (rsp_valid !== 2'b10 || rsp_data !== {32{8'hA5}}) begin
      bad++;
      $display("[TB] FAIL readback got valid=%b data=%h exp valid=10 data=a5..", rsp_valid, rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int g;
    int g0;
    int g1;
    int rsp_n;
    int rsp_bad;
    int ov0;
    int bs0;
    logic [7:0] gseq;
    logic last_owner;
    logic [1:0] exp_v;
    logic [255:0] exp_d;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_lat = 3;
    req_we = 2'b00;
    req_addr0 = 32'h0000_1000;
    req_addr1 = 32'h0000_2000;
    req_valid = 2'b11;
    g = 0; g0 = 0; g1 = 0; rsp_n = 0; rsp_bad = 0;
    gseq = 8'h00;
    last_owner = 1'b0;
    ov0 = overlap;
    bs0 = both_strobe;
    for (int c = 0; c < 400 && (g < 8 || rsp_n < 8); c++) begin
      @(negedge clk);
      if (req_ready == 2'b11)
        rsp_bad++;
      if (req_ready[0]) begin
        g++; g0++;
        last_owner = 1'b0;
        if (g0 == 4) req_valid[0] = 1'b0;
      end
      if (req_ready[1]) begin
        if (g < 8) gseq[g] = 1'b1;
        g++; g1++;
        last_owner = 1'b1;
        if (g1 == 4) req_valid[1] = 1'b0;
      end
      if (rsp_valid != 2'b00) begin
        rsp_n++;
        exp_v = last_owner ? 2'b10 : 2'b01;
        exp_d = last_owner ? {8{32'h0000_2000}} : {8{32'h0000_1000}};
        if (rsp_valid !== exp_v || rsp_data !== exp_d)
          rsp_bad++;
      end
    end
    req_valid = 2'b00;
    total++;
    if (g !== 8 || gseq !== 8'hAA) begin
      bad++;
      $display("[TB] FAIL rr_order got n=%0d seq=%b exp n=8 seq=10101010", g, gseq);
    end
    total++;
    if (rsp_n !== 8 || rsp_bad !== 0) begin
      bad++;
      $display("[TB] FAIL rr_routing got rsp=%0d bad=%0d exp rsp=8 bad=0", rsp_n, rsp_bad);
    end
    total++;
    if (overlap - ov0 !== 0 || both_strobe - bs0 !== 0) begin
      bad++;
      $display("[TB] FAIL rr_outstanding got overlap=%0d both=%0d exp 0 0", overlap - ov0, both_strobe - bs0);
    end
    rd_lat = 5;
    @(negedge clk);
  endtask

  task automatic test_busy_dram();
    int viol;
    int n;
    busy_r = 1'b1;
    req_addr0 = 32'h0000_3000;
    req_we = 2'b00;
    req_valid = 2'b01;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00 || mem_en)
        viol++;
    end
    total++;
    if (viol !== 0) begin
      bad++;
      $display("[TB] FAIL busy_hold got issues=%0d exp=0", viol);
    end
    busy_r = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 2'b01 || mem_en !== 1'b1) begin
      bad++;
      $display("[TB] FAIL busy_release got ready=%b en=%b exp ready=01 en=1", req_ready, mem_en);
    end
    req_valid = 2'b00;
    wait_rsp(n);
    total++;
    if (rsp_valid !== 2'b01 || rsp_data !== {8{32'h0000_3000}}) begin
      bad++;
      $display("[TB] FAIL busy_rsp got valid=%b data=%h", rsp_valid, rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    no_dready = 1'b1;
    req_addr0 = 32'h0000_4000;
    req_valid = 2'b01;
    wait_ready(0, ok);
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid == 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!ok || n !== 65) begin
      bad++;
      $display("[TB] FAIL to_latency got ok=%b cycles=%0d exp ok=1 cycles=65", ok, n);
    end
    total++;
    if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_data !== '0) begin
      bad++;
      $display("[TB] FAIL to_rsp got valid=%b err=%b data=%h exp 01 1 0", rsp_valid, rsp_err, rsp_data);
    end
    total++;
    if (err_sticky !== 1'b1) begin
      bad++;
      $display("[TB] FAIL to_sticky got=%b exp=1", err_sticky);
    end
    @(negedge clk);
    total++;
    if (rsp_err !== 1'b0 || err_sticky !== 1'b1) begin
      bad++;
      $display("[TB] FAIL to_clear got err=%b sticky=%b exp err=0 sticky=1", rsp_err, err_sticky);
    end
    no_dready = 1'b0;
    req_addr0 = 32'h0000_5000;
    req_valid = 2'b01;
    wait_ready(0, ok);
    req_valid = 2'b00;
    wait_rsp(n);
    total++;
    if (!ok || rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_data !== {8{32'h0000_5000}}) begin
      bad++;
      $display("[TB] FAIL to_recover got valid=%b err=%b data=%h", rsp_valid, rsp_err, rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int base;
    int n;
    rd_lat = 20;
    req_addr0 = 32'h0000_6000;
    req_valid = 2'b01;
    wait_ready(0, ok);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_err, mem_en, mem_we, err_sticky} !== 8'h00 || mem_addr !== 32'h0 || rsp_data !== '0) begin
      bad++;
      $display("[TB] FAIL midrst_outputs got ctrl=%b addr=%h exp 0", {req_ready, rsp_valid, rsp_err, mem_en, mem_we, err_sticky}, mem_addr);
    end
    reset = 1'b0;
    rd_lat = 5;
    base = rsp_seen;
    repeat (25) @(negedge clk);
    total++;
    if (rsp_seen !== base) begin
      bad++;
      $display("[TB] FAIL midrst_no_rsp got=%0d exp=0", rsp_seen - base);
    end
    req_addr0 = 32'h0000_7000;
    req_addr1 = 32'h0000_8000;
    req_valid = 2'b11;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 2'b00 && n < 100);
    req_valid = 2'b10;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("[TB] FAIL midrst_ptr got=%b exp=01", req_ready);
    end
    wait_ready(1, ok);
    req_valid = 2'b00;
    wait_rsp(n);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_readback();
    test_contention();
    test_busy_dram();
    test_timeout();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
